multicycle_controller: RTL

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/ctrl_pkg.sv | 36 +++
 rtl/wait_timer.sv | 31 +++
 rtl/multicycle_controller.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle controller: state encoding,
// instruction opcodes and fault codes.
package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10,
        ERROR    = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b01;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b10;

    // States that stall on the memory handshake and are guarded by the wait timer.
    function automatic logic is_mem_wait(input state_t s);
        return (s == FETCH) || (s == MEMREAD) || (s == MEMWRITE);
    endfunction

endpackage

// File: rtl/wait_timer.sv
// Saturating counter of consecutive memory-wait cycles. expired flags the
// LIMIT-th consecutive low cycle so the FSM can abandon the access.
module wait_timer #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic count,
    output logic expired
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt_q;

    // Clear has priority; otherwise count up and stick at LIMIT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (count && (cnt_q != W'(LIMIT))) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    // This cycle would be the LIMIT-th consecutive wait with no completion.
    assign expired = count && (cnt_q >= W'(LIMIT - 1));

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for a multicycle RISC-V style datapath (lw, sw, R, I,
// beq, jal) with a memory-wait watchdog and sticky fault reporting.
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT = 255
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_write,
    output logic       adr_src,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] fault,
    output logic [3:0] state_dbg
);

    state_t state_q;
    logic   in_wait;
    logic   wt_clear;
    logic   wt_count;
    logic   wt_expired;

    // Counter is held at zero outside wait states, so every entry starts fresh.
    assign in_wait  = is_mem_wait(state_q);
    assign wt_clear = !in_wait || mem_ready;
    assign wt_count = in_wait && !mem_ready;

    wait_timer #(.LIMIT(WAIT_LIMIT)) u_wait_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (wt_clear),
        .count   (wt_count),
        .expired (wt_expired)
    );

    assign state_dbg = state_q;

    // State sequencing plus sticky fault code, both cleared only by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FETCH;
            fault   <= FAULT_NONE;
        end else begin
            case (state_q)
                FETCH: begin
                    if (mem_ready) begin
                        state_q <= DECODE;
                    end else if (wt_expired) begin
                        state_q <= ERROR;
                        fault   <= FAULT_TIMEOUT;
                    end
                end
                DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW: state_q <= MEMADR;
                        OP_RTYPE:     state_q <= EXECR;
                        OP_ITYPE:     state_q <= EXECI;
                        OP_BEQ:       state_q <= BEQ;
                        OP_JAL:       state_q <= JAL;
                        default: begin
                            state_q <= ERROR;
                            fault   <= FAULT_ILLEGAL;
                        end
                    endcase
                end
                MEMADR:  state_q <= (opcode == OP_SW) ? MEMWRITE : MEMREAD;
                MEMREAD: begin
                    if (mem_ready) begin
                        state_q <= MEMWB;
                    end else if (wt_expired) begin
                        state_q <= ERROR;
                        fault   <= FAULT_TIMEOUT;
                    end
                end
                MEMWB:   state_q <= FETCH;
                MEMWRITE: begin
                    if (mem_ready) begin
                        state_q <= FETCH;
                    end else if (wt_expired) begin
                        state_q <= ERROR;
                        fault   <= FAULT_TIMEOUT;
                    end
                end
                EXECR, EXECI: state_q <= ALUWB;
                ALUWB:   state_q <= FETCH;
                BEQ:     state_q <= FETCH;
                JAL:     state_q <= ALUWB;
                ERROR:   state_q <= ERROR;
                default: state_q <= ERROR;
            endcase
        end
    end

    // Output decode from the state register; FETCH enables follow mem_ready
    // and the branch PC enable follows zero.
    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        case (state_q)
            FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            MEMREAD: adr_src = 1'b1;
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
            end
            ALUWB: reg_write = 1'b1;
            BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                pc_write  = zero;
            end
            JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
